// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// led_ctrl_pkg : mode/state encodings and counter widths for led_pattern_ctrl
// Revision     : 1.0
// ============================================================================
package led_ctrl_pkg;

  localparam int RATE_W  = 4;
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// tick_gen : free-running base-tick prescaler, restartable through clear
// Revision : 1.0
// ============================================================================
module tick_gen #(
  parameter int TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// led_pattern_ctrl : command-driven OFF/SOLID/BLINK/CHASE sequencer for LEDs
// Revision         : 1.0
// ============================================================================
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 6250000,
  parameter int NUM_LEDS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [RATE_W-1:0]   cmd_rate,
  input  logic [COUNT_W-1:0]  cmd_count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [NUM_LEDS-1:0] led
);

  localparam logic [NUM_LEDS-1:0] LED_BIT0 = NUM_LEDS'(1);

  state_t               state;
  state_t               next_state;
  mode_t                cur_mode;
  logic [RATE_W-1:0]    cur_rate;
  logic [COUNT_W-1:0]   cur_count;
  logic [RATE_W-1:0]    rate_cnt;
  logic [COUNT_W-1:0]   step_cnt;
  logic [COUNT_W-1:0]   step_cnt_inc;
  logic                 dir_down;
  logic                 tick;
  logic                 accept;
  logic                 step;
  logic                 last_step;
  logic [NUM_LEDS-1:0]  load_pattern;
  logic [NUM_LEDS-1:0]  step_pattern;
  logic [NUM_LEDS-1:0]  chase_next;
  logic                 chase_dir_next;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick)
  );

  assign accept       = cmd_valid && (state == ST_IDLE);
  assign step         = (state == ST_RUN) && tick && (rate_cnt == cur_rate);
  assign step_cnt_inc = step_cnt + 1'b1;
  assign last_step    = step && (cur_count != '0) && (step_cnt_inc == cur_count);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM: next state; abort wins over a coincident completion
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept && (mode_t'(cmd_mode) != MODE_OFF)) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort || last_step) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state == ST_RUN);
  end

  always_comb begin
    case (mode_t'(cmd_mode))
      MODE_SOLID, MODE_BLINK: load_pattern = '1;
      MODE_CHASE:             load_pattern = LED_BIT0;
      default:                load_pattern = '0;
    endcase
  end

  // Chase bounces: reaching an end bit reverses and moves back in the same step
  generate
    if (NUM_LEDS == 1) begin : g_chase_single
      assign chase_next     = led;
      assign chase_dir_next = dir_down;
    end else begin : g_chase_multi
      always_comb begin
        chase_next     = led;
        chase_dir_next = dir_down;
        if (!dir_down) begin
          if (led[NUM_LEDS-1]) begin
            chase_dir_next = 1'b1;
            chase_next     = led >> 1;
          end else begin
            chase_next     = led << 1;
          end
        end else begin
          if (led[0]) begin
            chase_dir_next = 1'b0;
            chase_next     = led << 1;
          end else begin
            chase_next     = led >> 1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    case (cur_mode)
      MODE_BLINK: step_pattern = ~led;
      MODE_CHASE: step_pattern = chase_next;
      default:    step_pattern = led;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mode  <= MODE_OFF;
      cur_rate  <= '0;
      cur_count <= '0;
      rate_cnt  <= '0;
      step_cnt  <= '0;
      dir_down  <= 1'b0;
      led       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cur_mode  <= mode_t'(cmd_mode);
        cur_rate  <= cmd_rate;
        cur_count <= cmd_count;
        rate_cnt  <= '0;
        step_cnt  <= '0;
        dir_down  <= 1'b0;
        led       <= load_pattern;
      end else if (state == ST_RUN) begin
        if (abort) begin
          led <= '0;
        end else if (tick) begin
          if (step) begin
            rate_cnt <= '0;
            // saturates so an endless run never wraps into a false match
            if (step_cnt != '1) begin
              step_cnt <= step_cnt_inc;
            end
            if (last_step) begin
              led  <= '0;
              done <= 1'b1;
            end else begin
              led <= step_pattern;
              if (cur_mode == MODE_CHASE) begin
                dir_down <= chase_dir_next;
              end
            end
          end else begin
            rate_cnt <= rate_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// tb_led_pattern_ctrl : vector table, corner sequences and random model check
// Revision            : 1.0
// ============================================================================
module tb_led_pattern_ctrl;
  import led_ctrl_pkg::*;

  localparam int TDIV = 4;
  localparam int NL   = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_mode  = 2'd0;
  logic [3:0]    cmd_rate  = 4'd0;
  logic [7:0]    cmd_count = 8'd0;
  logic          abort     = 1'b0;
  logic          cmd_ready;
  logic          busy;
  logic          done;
  logic [NL-1:0] led;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .TICK_DIV (TDIV),
    .NUM_LEDS (NL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_rate  (cmd_rate),
    .cmd_count (cmd_count),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .led       (led)
  );

  typedef struct {
    logic          valid;
    logic [1:0]    mode;
    logic [3:0]    rate;
    logic [7:0]    count;
    logic          abrt;
    int            adv;
    logic [NL-1:0] exp_led;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [NL-1:0] el,
                       input logic eb, input logic ed, input logic er);
    checks++;
    if (led !== el || busy !== eb || done !== ed || cmd_ready !== er) begin
      errors++;
      $display("FAIL %s: got led=%b busy=%b done=%b ready=%b, expected led=%b busy=%b done=%b ready=%b",
               name, led, busy, done, cmd_ready, el, eb, ed, er);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic [1:0] m, input logic [3:0] r,
                              input logic [7:0] c, input logic a, input int adv,
                              input logic [NL-1:0] el, input logic eb, input logic ed);
    vec_t t;
    t.valid = v; t.mode = m; t.rate = r; t.count = c; t.abrt = a; t.adv = adv;
    t.exp_led = el; t.exp_busy = eb; t.exp_done = ed;
    vecs.push_back(t);
  endfunction

  // Reference: pattern shown after s completed steps, from the mode rules alone
  function automatic logic [NL-1:0] pat(input logic [1:0] mode, input int s);
    logic [NL-1:0] ones = '1;
    logic [NL-1:0] one  = NL'(1);
    int per;
    int p;
    case (mode)
      2'd1: return ones;
      2'd2: return (s % 2 == 0) ? ones : '0;
      2'd3: begin
        if (NL == 1) return one;
        per = 2 * (NL - 1);
        p   = s % per;
        if (p >= NL) p = per - p;
        return one << p;
      end
      default: return '0;
    endcase
  endfunction

  logic          m_run;
  int            m_k;
  logic [1:0]    m_mode;
  int            m_rate;
  int            m_count;
  logic [NL-1:0] m_led;
  logic          m_done;

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("in_reset", 4'b0000, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      edges(1);
      check("reset_idle", 4'b0000, 1'b0, 1'b0, 1'b1);
    end

    // BLINK rate=1 count=3
    add(1, MODE_BLINK, 1, 3, 0, 1, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 7, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 1, 0);
    add(0, 0, 0, 0, 0, 8, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 7, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 0, 1);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
    // CHASE rate=0 forever, SOLID ignored while running, then abort
    add(1, MODE_CHASE, 0, 0, 0, 1, 4'b0001, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0010, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0100, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0100, 1, 0);
    add(1, MODE_SOLID, 0, 1, 0, 1, 4'b0100, 1, 0);
    add(0, 0, 0, 0, 0, 2, 4'b1000, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0100, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0010, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0001, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0010, 1, 0);
    add(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
    // Abort on the completion edge, then BLINK accepted next cycle
    add(1, MODE_SOLID, 0, 2, 0, 1, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 3, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
    add(1, MODE_BLINK, 0, 0, 0, 1, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0000, 1, 0);
    add(1, MODE_OFF, 0, 0, 0, 1, 4'b0000, 1, 0);
    add(0, 0, 0, 0, 0, 3, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 1, 1, 4'b0000, 0, 0);
    // OFF in IDLE
    add(1, MODE_OFF, 0, 0, 0, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
    // count=1 completion, new command on the very next cycle
    add(1, MODE_SOLID, 0, 1, 0, 1, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 3, 4'b1111, 1, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 0, 1);
    add(1, MODE_CHASE, 0, 1, 0, 1, 4'b0001, 1, 0);
    add(0, 0, 0, 0, 0, 4, 4'b0000, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cmd_valid = vecs[i].valid;
      cmd_mode  = vecs[i].mode;
      cmd_rate  = vecs[i].rate;
      cmd_count = vecs[i].count;
      abort     = vecs[i].abrt;
      edges(1);
      cmd_valid = 1'b0;
      abort     = 1'b0;
      if (vecs[i].adv > 1) edges(vecs[i].adv - 1);
      check($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_busy,
            vecs[i].exp_done, ~vecs[i].exp_busy);
    end

    // Asynchronous reset mid-run
    edges(1);
    cmd_valid = 1'b1; cmd_mode = MODE_BLINK; cmd_rate = 4'd1; cmd_count = 8'd0;
    edges(1);
    cmd_valid = 1'b0;
    edges(5);
    check("pre_reset_run", 4'b1111, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'b0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    edges(1);
    check("post_reset", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Slowest rate, single step: completion 64 edges after accept
    cmd_valid = 1'b1; cmd_mode = MODE_BLINK; cmd_rate = 4'd15; cmd_count = 8'd1;
    edges(1);
    cmd_valid = 1'b0;
    edges(63);
    check("rate15_before", 4'b1111, 1'b1, 1'b0, 1'b0);
    edges(1);
    check("rate15_done", 4'b0000, 1'b0, 1'b1, 1'b1);
    edges(1);
    check("rate15_after", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Randomized commands and aborts against the reference model
    m_run = 1'b0; m_k = 0; m_mode = 2'd0; m_rate = 0; m_count = 0; m_led = '0;
    for (int c = 0; c < 1500; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_mode  = 2'($urandom_range(0, 3));
      cmd_rate  = 4'($urandom_range(0, 2));
      cmd_count = 8'($urandom_range(0, 4));
      abort     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      m_done = 1'b0;
      if (!m_run) begin
        if (cmd_valid) begin
          m_led = pat(cmd_mode, 0);
          if (cmd_mode != 2'd0) begin
            m_run = 1'b1; m_k = 0; m_mode = cmd_mode;
            m_rate = int'(cmd_rate); m_count = int'(cmd_count);
          end
        end
      end else begin
        m_k++;
        if (abort) begin
          m_run = 1'b0; m_led = '0;
        end else if (m_count != 0 && m_k == m_count * TDIV * (m_rate + 1)) begin
          m_run = 1'b0; m_led = '0; m_done = 1'b1;
        end else begin
          m_led = pat(m_mode, m_k / (TDIV * (m_rate + 1)));
        end
      end
      #1 check($sformatf("rand%0d", c), m_led, m_run, m_done, ~m_run);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
